// File: rtl/cryptopen_sha1_pkg.sv
// Shared SHA-1 schedule types, round/block constants and recurrence tap positions.
package cryptopen_sha1_pkg;

  typedef logic [31:0] sha1_word_t;

  localparam int SHA1_ROUNDS      = 80;
  localparam int SHA1_BLOCK_WORDS = 16;

  // Window offsets of W[t-3], W[t-8], W[t-14], W[t-16] relative to the word being emitted.
  localparam int TAP_A = 13;
  localparam int TAP_B = 8;
  localparam int TAP_C = 2;
  localparam int TAP_D = 0;

  typedef enum logic {
    LOAD,
    EXPAND
  } sched_state_e;

endpackage

// File: rtl/prim_generic_rotl.sv
// Constant-distance left rotate; purely combinational, no backpressure.
module prim_generic_rotl #(
  parameter int Width    = 32,
  parameter int Position = 1
) (
  input  logic [Width-1:0] value,
  output logic [Width-1:0] result
);

  assign result = (value << Position) | (value >> (Width - Position));

endmodule

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: loads 16 words, streams W[0..79]; 1-cycle load-to-valid latency, holds under stall.
// Optional CRYPTOPEN_SCHED_ZEROIZE_EN wipes the window after the last word and on clear_i.
module sha1_msg_schedule
  import cryptopen_sha1_pkg::*;
#(
  parameter int Width      = 32,
  parameter int NumRounds  = SHA1_ROUNDS,
  parameter int BlockWords = SHA1_BLOCK_WORDS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_word_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_word_o,
  output logic [6:0]       out_idx_o,
  output logic             out_last_o
);

  localparam int CntW = $clog2(BlockWords);

  sched_state_e    state_q, state_d;
  logic [CntW-1:0] load_cnt;
  logic [6:0]      idx;
  logic [Width-1:0] win [BlockWords];
  logic [Width-1:0] tap_xor, next_word;
  logic            in_fire, out_fire, last_fire, load_done;

  assign in_ready_o  = (state_q == LOAD);
  assign out_valid_o = (state_q == EXPAND);
  assign out_word_o  = win[0];
  assign out_idx_o   = idx;
  assign out_last_o  = out_valid_o & (idx == 7'(NumRounds - 1));

  // clear_i swallows any handshake presented in the same cycle.
  assign in_fire   = in_valid_i & in_ready_o & ~clear_i;
  assign out_fire  = out_valid_o & out_ready_i & ~clear_i;
  assign last_fire = out_fire & out_last_o;
  assign load_done = in_fire & (load_cnt == CntW'(BlockWords - 1));

  assign tap_xor = win[TAP_A] ^ win[TAP_B] ^ win[TAP_C] ^ win[TAP_D];

  prim_generic_rotl #(
    .Width   (Width),
    .Position(1)
  ) u_rotl (
    .value (tap_xor),
    .result(next_word)
  );

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (load_done) state_d = EXPAND;
        EXPAND:  if (last_fire) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      load_cnt <= '0;
      idx      <= '0;
    end else begin
      if (in_fire)  load_cnt <= load_done ? '0 : load_cnt + 1'b1;
      if (out_fire) idx      <= last_fire ? '0 : idx + 7'd1;
    end
  end

  // The last handshake does not shift, so win[0] keeps W[NumRounds-1] once the block is done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BlockWords; i++) win[i] <= '0;
`ifdef CRYPTOPEN_SCHED_ZEROIZE_EN
    end else if (clear_i || last_fire) begin
      for (int i = 0; i < BlockWords; i++) win[i] <= '0;
`endif
    end else if (in_fire) begin
      win[load_cnt] <= in_word_i;
    end else if (out_fire && !out_last_o) begin
      for (int i = 0; i < BlockWords - 1; i++) win[i] <= win[i+1];
      win[BlockWords-1] <= next_word;
    end
  end

endmodule
